wg_fetch_ctrl: RTL and testbench
================================

Name: wg_fetch_ctrl

Overview:
- Sequencer for the LSTM gate-weight ROM: generates its 8-bit address and streams one ROM word per cycle to the gate MAC array over a valid/ready handshake.
- Each word is UNITS_NUM packed D_WL-bit weights.
- One command selects a contiguous address window and a repeat count, so the same window can be replayed for several timesteps.
- Sits between the layer scheduler (command side) and the MAC units (stream side); the ROM is combinational and driven only by this block.

Parameters:
- D_WL, 24, weight word length in bits
- UNITS_NUM, 5, weights per ROM word
- DEPTH, 156, ROM entry count
- AW, 8, ROM address width
- RW, 4, repeat-count width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  command strobe; sampled only in IDLE
- base_i  in  AW  first address of window
- len_i  in  AW  window length in words
- rep_i  in  RW  extra passes; total passes = rep_i+1
- busy_o  out  1  high from command acceptance until done_o
- done_o  out  1  one-cycle pulse after final word is accepted
- err_o  out  1  one-cycle pulse on a rejected command
- rom_addr_o  out  AW  ROM address, registered
- rom_data_i  in  UNITS_NUM*D_WL  ROM read data (combinational from rom_addr_o)
- w_data_o  out  UNITS_NUM*D_WL  weight word to MACs, registered
- w_valid_o  out  1  w_data_o valid
- w_ready_i  in  1  consumer accepts w_data_o
- w_first_o  out  1  qualifies first word of each pass
- w_last_o  out  1  qualifies final word of final pass

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous active-low):
  - State goes to IDLE.
  - All outputs go to 0, including rom_addr_o and w_data_o.
  - Internal counters are cleared.
  - Reset mid-command aborts the command. No done_o, no err_o.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i, validate the command.
  - Reject if len_i==0 or base_i+len_i>DEPTH; the sum is computed at AW+1 bits.
  - Rejected: err_o=1 for one cycle; stay IDLE.
  - Accepted: latch base, end=base+len-1 and rep; rom_addr_o<=base_i; busy_o<=1; go to RUN.
- RUN:
  - adv = !w_valid_o || w_ready_i.
  - On adv: w_data_o<=rom_data_i, w_valid_o<=1, w_first_o<=(rom_addr_o==base), w_last_o<=(rom_addr_o==end && pass==rep).
  - Address update on adv: rom_addr_o<=(rom_addr_o==end) ? base : rom_addr_o+1.
  - Pass counter increments when the address wraps.
  - When the last word is loaded, go to DRAIN.
  - Start-to-first-valid latency is 2 cycles (command cycle, then first-load cycle).
  - Full throughput of 1 word/cycle while w_ready_i=1.
- DRAIN: wait for w_valid_o && w_ready_i. Then clear w_valid_o, w_first_o and w_last_o; go to DONE.
- DONE: done_o=1 for one cycle; busy_o<=0; go to IDLE. A start_i in this cycle is ignored.
- Handshake rules:
  - w_data_o, w_first_o and w_last_o are stable while w_valid_o && !w_ready_i.
  - w_valid_o never deasserts without acceptance.
- start_i while busy is ignored; no error is raised.
- len_i==1 is legal: every word carries w_first_o=1; w_last_o is set on the final pass only.
- base_i+len_i==DEPTH is legal; the highest address read is 155.

Optional Feature:
- Macro: WG_FETCH_PERF_EN.
- When defined, adds output stall_cnt_o (16 bits).
  - Counts cycles with w_valid_o && !w_ready_i.
  - Cleared on command acceptance; saturates at 'hFFFF.
  - Holds its value after done_o.
- When undefined, the port and logic are absent.

Decomposition:
- Shared package wg_pkg holds:
  - D_WL, UNITS_NUM, DEPTH and AW defaults
  - The FSM state enum (IDLE/RUN/DRAIN/DONE)
  - The word type of width UNITS_NUM*D_WL
- Natural sub-module: wg_addr_gen, holding the base/end/wrap address counter and the pass counter, with outputs addr, at_end and last_pass.
- FSM and output register stay in wg_fetch_ctrl.
- Top-level integration instantiates wg_fetch_ctrl next to the ROM.

Test Plan:
- Basic burst: base=0, len=3, rep=0, ready held 1.
  - Words for addr 0,1,2 stream on consecutive cycles; first word = 'h0002b900109ffff8440004790003ee.
  - w_first_o on word0, w_last_o on word2.
  - done_o one cycle after word2 is accepted; busy_o then drops.
- Backpressure: base=10, len=4, ready toggled 1,0,0,1,...
  - No word is lost or duplicated; the sequence is addr 10..13.
  - w_data_o is stable through stalls.
  - With WG_FETCH_PERF_EN, stall_cnt_o equals the number of stall cycles.
- Repeat/wrap: base=154, len=2, rep=2.
  - Six words on addr 154,155,154,155,154,155.
  - w_first_o on words 0, 2 and 4; w_last_o only on word 5.
- Rejection: base=150, len=10 → err_o pulse, busy_o stays 0, no w_valid_o. Same for len=0. base=146, len=10 is accepted and ends at addr 155.
- Reset mid-run: base=0, len=50; assert rst_n=0 after 5 accepted words.
  - Next edge: all outputs 0, state IDLE, no done_o.
  - A new command then starts cleanly.
- Busy start: start_i asserted during RUN with a different base → ignored; the original stream completes unchanged.

Source files
------------

// File: rtl/wg_pkg.sv
// wg_pkg: shared defaults, FSM state enum and ROM word type for the gate-weight fetch sequencer
package wg_pkg;
   localparam int D_WL      = 24;
   localparam int UNITS_NUM = 5;
   localparam int DEPTH     = 156;
   localparam int AW        = 8;
   localparam int RW        = 4;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef logic [UNITS_NUM*D_WL-1:0] word_t;
endpackage

// File: rtl/wg_addr_gen.sv
// wg_addr_gen: window address counter wrapping end->base, plus pass counter against the repeat count
module wg_addr_gen #(
   parameter int AW = wg_pkg::AW,
   parameter int RW = wg_pkg::RW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          adv,
   input  logic [AW-1:0] base_i,
   input  logic [AW-1:0] end_i,
   input  logic [RW-1:0] rep_i,
   output logic [AW-1:0] addr,
   output logic          at_base,
   output logic          at_end,
   output logic          last_pass
);
   import wg_pkg::*;
   logic [AW-1:0] base_r, end_r;
   logic [RW-1:0] rep_r, pass;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_r <= '0;
         end_r  <= '0;
         rep_r  <= '0;
         pass   <= '0;
         addr   <= '0;
      end else if (load) begin
         base_r <= base_i;
         end_r  <= end_i;
         rep_r  <= rep_i;
         pass   <= '0;
         addr   <= base_i;
      end else if (adv) begin
         addr <= at_end ? base_r : addr + 1'b1;
         if (at_end) pass <= pass + 1'b1;
      end
   end
   assign at_base   = addr == base_r;
   assign at_end    = addr == end_r;
   assign last_pass = pass == rep_r;
endmodule

// File: rtl/wg_fetch_ctrl.sv
// wg_fetch_ctrl: gate-weight ROM sequencer streaming one word per cycle; WG_FETCH_PERF_EN adds stall_cnt_o
module wg_fetch_ctrl #(
   parameter int D_WL      = wg_pkg::D_WL,
   parameter int UNITS_NUM = wg_pkg::UNITS_NUM,
   parameter int DEPTH     = wg_pkg::DEPTH,
   parameter int AW        = wg_pkg::AW,
   parameter int RW        = wg_pkg::RW
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [AW-1:0]             base_i,
   input  logic [AW-1:0]             len_i,
   input  logic [RW-1:0]             rep_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic [AW-1:0]             rom_addr_o,
   input  logic [UNITS_NUM*D_WL-1:0] rom_data_i,
   output logic [UNITS_NUM*D_WL-1:0] w_data_o,
   output logic                      w_valid_o,
   input  logic                      w_ready_i,
   output logic                      w_first_o,
   output logic                      w_last_o
`ifdef WG_FETCH_PERF_EN
   ,output logic [15:0]              stall_cnt_o
`endif
);
   import wg_pkg::*;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   state_t state, state_nx;
   logic accept, reject, adv, cmd_ok, at_base, at_end, last_pass;
   logic [AW:0] sum;
   logic [AW-1:0] end_w;
   assign sum    = {1'b0, base_i} + {1'b0, len_i};
   assign end_w  = base_i + len_i - 1'b1;
   assign cmd_ok = len_i != '0 && sum <= DEPTH_W;
   assign done_o = state == DONE;
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      reject   = 1'b0;
      adv      = 1'b0;
      case (state)
         IDLE: begin
            accept   = start_i && cmd_ok;
            reject   = start_i && !cmd_ok;
            state_nx = accept ? RUN : IDLE;
         end
         RUN: begin
            adv      = !w_valid_o || w_ready_i;
            state_nx = (adv && at_end && last_pass) ? DRAIN : RUN;
         end
         DRAIN:   state_nx = (w_valid_o && w_ready_i) ? DONE : DRAIN;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   wg_addr_gen #(.AW(AW), .RW(RW)) u_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .adv       (adv),
      .base_i    (base_i),
      .end_i     (end_w),
      .rep_i     (rep_i),
      .addr      (rom_addr_o),
      .at_base   (at_base),
      .at_end    (at_end),
      .last_pass (last_pass)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_o    <= 1'b0;
         err_o     <= 1'b0;
         w_data_o  <= '0;
         w_valid_o <= 1'b0;
         w_first_o <= 1'b0;
         w_last_o  <= 1'b0;
      end else begin
         err_o <= reject;
         if (accept)             busy_o <= 1'b1;
         else if (state == DONE) busy_o <= 1'b0;
         if (adv) begin
            w_data_o  <= rom_data_i;
            w_valid_o <= 1'b1;
            w_first_o <= at_base;
            w_last_o  <= at_end && last_pass;
         end else if (state == DRAIN && w_valid_o && w_ready_i) begin
            w_valid_o <= 1'b0;
            w_first_o <= 1'b0;
            w_last_o  <= 1'b0;
         end
      end
   end
`ifdef WG_FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n || accept)                                          stall_cnt_o <= '0;
      else if (w_valid_o && !w_ready_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 1'b1;
   end
`endif
endmodule

// File: tb/tb_wg_fetch_ctrl.sv
// tb_wg_fetch_ctrl: directed self-checking bench with a combinational ROM model beside the sequencer
module tb_wg_fetch_ctrl;
   import wg_pkg::*;
   logic clk = 1'b0;
   logic rst_n, start_i, w_ready_i;
   logic [7:0] base_i, len_i, rom_addr_o;
   logic [3:0] rep_i;
   logic busy_o, done_o, err_o, w_valid_o, w_first_o, w_last_o;
   word_t rom_data_i, w_data_o;
`ifdef WG_FETCH_PERF_EN
   logic [15:0] stall_cnt_o;
`endif
   int checks = 0, errors = 0;
   word_t got_data[64];
   logic [63:0] fmask, lmask;
   int n_got, first_acc, last_acc, done_cyc, stalls, unstable;

   always #5 clk = ~clk;

   function automatic word_t rom_word(input logic [7:0] a);
      logic [23:0] f;
      if (a == 8'd0) return 120'h0002b900109ffff8440004790003ee;
      f = {a, ~a, a ^ 8'h5A};
      return {5{f}};
   endfunction

   assign rom_data_i = rom_word(rom_addr_o);

   wg_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_i(base_i), .len_i(len_i), .rep_i(rep_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
      .w_data_o(w_data_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_first_o(w_first_o), .w_last_o(w_last_o)
`ifdef WG_FETCH_PERF_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   task automatic issue(input logic [7:0] b, input logic [7:0] l, input logic [3:0] r);
      start_i = 1'b1; base_i = b; len_i = l; rep_i = r;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready high every third cycle
   task automatic collect(input int mode, input int stop_after, input int poke_cyc, input int budget);
      word_t pd;
      logic pf, pl, ps;
      n_got = 0; first_acc = -1; last_acc = -1; done_cyc = -1; stalls = 0; unstable = 0;
      fmask = '0; lmask = '0; ps = 1'b0; pd = '0; pf = 1'b0; pl = 1'b0;
      for (int c = 0; c < budget; c++) begin
         w_ready_i = (mode == 0) ? 1'b1 : (c % 3 == 0);
         start_i = (c == poke_cyc);
         if (c == poke_cyc) begin base_i = 8'd100; len_i = 8'd3; rep_i = 4'd0; end
         #4;
         if (ps && (w_valid_o !== 1'b1 || w_data_o !== pd || w_first_o !== pf || w_last_o !== pl)) unstable++;
         if (done_o === 1'b1) begin done_cyc = c; break; end
         ps = w_valid_o && !w_ready_i; pd = w_data_o; pf = w_first_o; pl = w_last_o;
         if (ps) stalls++;
         if (w_valid_o && w_ready_i && n_got < 64) begin
            got_data[n_got] = w_data_o;
            fmask[n_got] = w_first_o;
            lmask[n_got] = w_last_o;
            n_got++;
            if (first_acc < 0) first_acc = c;
            last_acc = c;
            if (n_got == stop_after) break;
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; rep_i = '0; w_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy_o, done_o, err_o, w_valid_o, w_first_o, w_last_o} !== 6'b0) begin
         errors++; $display("FAIL reset_ctl: got %b expected 000000", {busy_o, done_o, err_o, w_valid_o, w_first_o, w_last_o});
      end
      checks++;
      if (rom_addr_o !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", rom_addr_o); end
      checks++;
      if (w_data_o !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", w_data_o); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      issue(8'd0, 8'd3, 4'd0);
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_o); end
      collect(0, -1, -1, 50);
      checks++;
      if (n_got !== 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", n_got); end
      checks++;
      if (got_data[0] !== 120'h0002b900109ffff8440004790003ee) begin
         errors++; $display("FAIL basic_word0: got %0h expected 2b900109ffff8440004790003ee", got_data[0]);
      end
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (got_data[i] !== rom_word(8'(i))) begin errors++; $display("FAIL basic_word%0d: got %0h expected %0h", i, got_data[i], rom_word(8'(i))); end
      end
      checks++;
      if (fmask[2:0] !== 3'b001 || lmask[2:0] !== 3'b100) begin
         errors++; $display("FAIL basic_flags: got first %b last %b expected 001 100", fmask[2:0], lmask[2:0]);
      end
      checks++;
      if (first_acc !== 1 || last_acc !== 3 || done_cyc !== 4) begin
         errors++; $display("FAIL basic_timing: got %0d/%0d/%0d expected 1/3/4", first_acc, last_acc, done_cyc);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL basic_end: got busy %b done %b expected 0 0", busy_o, done_o); end
   endtask

   task automatic test_backpressure;
      issue(8'd10, 8'd4, 4'd0);
      collect(1, -1, -1, 100);
      checks++;
      if (n_got !== 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_data[i] !== rom_word(8'(10 + i))) begin errors++; $display("FAIL bp_word%0d: got %0h expected %0h", i, got_data[i], rom_word(8'(10 + i))); end
      end
      checks++;
      if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
      checks++;
      if (stalls !== 8 || done_cyc !== 13) begin errors++; $display("FAIL bp_stalls: got %0d stalls done@%0d expected 8 done@13", stalls, done_cyc); end
`ifdef WG_FETCH_PERF_EN
      @(posedge clk); #1;
      checks++;
      if (stall_cnt_o !== 16'd8) begin errors++; $display("FAIL bp_perf: got %0d expected 8", stall_cnt_o); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_repeat;
      issue(8'd154, 8'd2, 4'd2);
      collect(0, -1, -1, 50);
      checks++;
      if (n_got !== 6) begin errors++; $display("FAIL rep_count: got %0d expected 6", n_got); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got_data[i] !== rom_word(8'(154 + i % 2))) begin errors++; $display("FAIL rep_word%0d: got %0h expected %0h", i, got_data[i], rom_word(8'(154 + i % 2))); end
      end
      checks++;
      if (fmask[5:0] !== 6'b010101 || lmask[5:0] !== 6'b100000) begin
         errors++; $display("FAIL rep_flags: got first %b last %b expected 010101 100000", fmask[5:0], lmask[5:0]);
      end
      checks++;
      if (done_cyc !== 7) begin errors++; $display("FAIL rep_done: got %0d expected 7", done_cyc); end
      @(posedge clk); #1;
   endtask

   task automatic test_reject;
      int viol;
      issue(8'd150, 8'd10, 4'd0);
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL rej_over: got err %b busy %b expected 1 0", err_o, busy_o); end
      @(posedge clk); #1;
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL rej_pulse: got %b expected 0", err_o); end
      viol = 0;
      for (int i = 0; i < 4; i++) begin
         if (w_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) viol++;
         @(posedge clk); #1;
      end
      checks++;
      if (viol !== 0) begin errors++; $display("FAIL rej_quiet: got %0d active cycles expected 0", viol); end
      issue(8'd50, 8'd0, 4'd0);
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL rej_len0: got err %b busy %b expected 1 0", err_o, busy_o); end
      @(posedge clk); #1;
      issue(8'd146, 8'd10, 4'd0);
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL acc_edge: got err %b busy %b expected 0 1", err_o, busy_o); end
      collect(0, -1, -1, 50);
      checks++;
      if (n_got !== 10 || done_cyc !== 11) begin errors++; $display("FAIL acc_count: got %0d words done@%0d expected 10 done@11", n_got, done_cyc); end
      checks++;
      if (got_data[9] !== rom_word(8'd155) || lmask[9] !== 1'b1) begin
         errors++; $display("FAIL acc_last: got %0h last %b expected %0h last 1", got_data[9], lmask[9], rom_word(8'd155));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int viol;
      issue(8'd0, 8'd50, 4'd0);
      collect(0, 5, -1, 100);
      checks++;
      if (n_got !== 5) begin errors++; $display("FAIL mid_count: got %0d expected 5", n_got); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy_o, done_o, err_o, w_valid_o, w_first_o, w_last_o} !== 6'b0 || rom_addr_o !== 8'd0 || w_data_o !== '0) begin
         errors++; $display("FAIL mid_reset: got ctl %b addr %0h data %0h expected all 0",
                             {busy_o, done_o, err_o, w_valid_o, w_first_o, w_last_o}, rom_addr_o, w_data_o);
      end
      rst_n = 1'b1;
      viol = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done_o !== 1'b0 || w_valid_o !== 1'b0 || err_o !== 1'b0) viol++;
      end
      checks++;
      if (viol !== 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", viol); end
      issue(8'd5, 8'd2, 4'd0);
      collect(0, -1, -1, 50);
      checks++;
      if (n_got !== 2 || got_data[0] !== rom_word(8'd5) || got_data[1] !== rom_word(8'd6) || fmask[1:0] !== 2'b01 || lmask[1:0] !== 2'b10) begin
         errors++; $display("FAIL mid_restart: got %0d words first %b last %b expected 2 words 01 10", n_got, fmask[1:0], lmask[1:0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_busy_start;
      int viol;
      issue(8'd20, 8'd4, 4'd0);
      collect(0, -1, 2, 50);
      checks++;
      if (n_got !== 4 || done_cyc !== 5) begin errors++; $display("FAIL busy_count: got %0d words done@%0d expected 4 done@5", n_got, done_cyc); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_data[i] !== rom_word(8'(20 + i))) begin errors++; $display("FAIL busy_word%0d: got %0h expected %0h", i, got_data[i], rom_word(8'(20 + i))); end
      end
      start_i = 1'b1; base_i = 8'd30; len_i = 8'd2;
      @(posedge clk); #1;
      start_i = 1'b0;
      viol = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy_o !== 1'b0 || w_valid_o !== 1'b0 || err_o !== 1'b0) viol++;
         @(posedge clk); #1;
      end
      checks++;
      if (viol !== 0) begin errors++; $display("FAIL busy_ignored: got %0d active cycles expected 0", viol); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_repeat;
      test_reject;
      test_reset_mid;
      test_busy_start;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
